// File: rtl/pwm_pkg.sv
// Shared mode encodings and capture FSM states for pwm_capture and timer_counter.
package pwm_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_CONT   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  function automatic logic is_capture_mode(input logic [1:0] m);
    return (m == MODE_SINGLE) || (m == MODE_CONT);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with single-cycle rise/fall strobes; strobes appear
// SYNC_STAGES clocks after the pin changes. No backpressure, no glitch filter.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   level;

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      prev <= level;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of pwm_in in prescaled ticks; results land one clock
// after the synchronised edge (SYNC_STAGES+1 clocks from the pin). No backpressure.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       control,
  input  logic [CNT_W-1:0] prescalor,
  input  logic [CNT_W-1:0] timeout,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             capture_int,
  output logic             timeout_flag,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [1:0]       prev_mode;
  logic [CNT_W-1:0] cnt_pres, cnt_pres_nxt;
  logic [CNT_W-1:0] count, count_nxt, count_inc;
  logic [CNT_W-1:0] high_cnt, high_cnt_nxt;
  logic [CNT_W-1:0] period_nxt, high_time_nxt;
  logic             valid_nxt, int_nxt, tflag_nxt;
  logic             tick, rise, fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .sig  (pwm_in),
    .rise (rise),
    .fall (fall)
  );

  assign tick      = (cnt_pres == prescalor);
  // Captures include the edge cycle's own tick, so an H-clock pulse at prescalor=0 reads H.
  assign count_inc = (tick && (count != '1)) ? count + CNT_W'(1) : count;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_pres_nxt  = '0;
    count_nxt     = count;
    high_cnt_nxt  = high_cnt;
    period_nxt    = period;
    high_time_nxt = high_time;
    valid_nxt     = 1'b0;
    int_nxt       = capture_int;
    tflag_nxt     = 1'b0;

    if (control != prev_mode) begin
      state_nxt = is_capture_mode(control) ? ARM : IDLE;
      count_nxt = '0;
      int_nxt   = 1'b0;
    end else if (state != IDLE) begin
      cnt_pres_nxt = (cnt_pres >= prescalor) ? '0 : cnt_pres + CNT_W'(1);
      count_nxt    = count_inc;
      if (rise && (state == HIGH || state == LOW)) begin
        period_nxt    = count_inc;
        high_time_nxt = (state == HIGH) ? count_inc : high_cnt;
        valid_nxt     = 1'b1;
        int_nxt       = 1'b1;
        count_nxt     = '0;
        cnt_pres_nxt  = '0;
        state_nxt     = (control == MODE_CONT) ? HIGH : IDLE;
      end else if (rise && state == ARM) begin
        count_nxt    = '0;
        cnt_pres_nxt = '0;
        state_nxt    = HIGH;
      end else if (fall && state == HIGH) begin
        high_cnt_nxt = count_inc;
        state_nxt    = LOW;
      end else if (!(rise || fall) && timeout != '0 && count == timeout) begin
        tflag_nxt    = 1'b1;
        count_nxt    = '0;
        cnt_pres_nxt = '0;
        state_nxt    = ARM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      prev_mode    <= MODE_OFF;
      cnt_pres     <= '0;
      count        <= '0;
      high_cnt     <= '0;
      period       <= '0;
      high_time    <= '0;
      valid        <= 1'b0;
      capture_int  <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      prev_mode    <= control;
      cnt_pres     <= cnt_pres_nxt;
      count        <= count_nxt;
      high_cnt     <= high_cnt_nxt;
      period       <= period_nxt;
      high_time    <= high_time_nxt;
      valid        <= valid_nxt;
      capture_int  <= int_nxt;
      timeout_flag <= tflag_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised bench for pwm_capture; expected results come from tick arithmetic
// (an interval of L clocks spans L/(prescalor+1) ticks) and edge timing of the drive.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  control;
  logic [31:0] prescalor;
  logic [31:0] timeout;
  logic        pwm_in;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        capture_int;
  logic        timeout_flag;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] vp[$];
  logic [31:0] vh[$];
  int          vt[$];
  int          tq[$];

  pwm_capture #(
    .SYNC_STAGES(2),
    .CNT_W      (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .control     (control),
    .prescalor   (prescalor),
    .timeout     (timeout),
    .pwm_in      (pwm_in),
    .period      (period),
    .high_time   (high_time),
    .valid       (valid),
    .capture_int (capture_int),
    .timeout_flag(timeout_flag),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vp.push_back(period);
      vh.push_back(high_time);
      vt.push_back(cyc);
    end
    if (timeout_flag) tq.push_back(cyc);
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    vp.delete();
    vh.delete();
    vt.delete();
    tq.delete();
  endtask

  // n full high/low periods followed by a closing rise held long enough to be captured
  task automatic run_pwm(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      tick_n(h);
      pwm_in = 1'b0;
      tick_n(p - h);
    end
    pwm_in = 1'b1;
    tick_n(8);
  endtask

  task automatic arm(input int ps, input logic [1:0] mode);
    control   = 2'b00;
    pwm_in    = 1'b0;
    timeout   = 32'd0;
    prescalor = 32'(ps);
    tick_n(4);
    control = mode;
    tick_n(4);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    control   = 2'($urandom);
    prescalor = $urandom_range(0, 5);
    timeout   = $urandom_range(0, 5);
    pwm_in    = 1'($urandom);
    tick_n(3);
    total++; if (period !== 32'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", period); end
    total++; if (high_time !== 32'd0) begin bad++; $display("FAIL reset_high: got %0d want 0", high_time); end
    total++; if ({valid, capture_int, timeout_flag, busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {valid, capture_int, timeout_flag, busy});
    end
    control   = 2'b00;
    prescalor = 32'd0;
    timeout   = 32'd0;
    pwm_in    = 1'b0;
    reset     = 1'b1;
    tick_n(4);
  endtask

  task automatic test_timeout();
    arm(0, 2'b00);
    timeout = 32'd50;
    clear_q();
    control = 2'b10;
    tick_n(300);
    total++; if (tq.size() != 5) begin bad++; $display("FAIL timeout_count: got %0d want 5", tq.size()); end
    for (int i = 1; i < tq.size(); i++) begin
      total++; if (tq[i] - tq[i-1] != 51) begin
        bad++; $display("FAIL timeout_spacing[%0d]: got %0d want 51", i, tq[i] - tq[i-1]);
      end
    end
    total++; if (vp.size() != 0) begin bad++; $display("FAIL timeout_novalid: got %0d want 0", vp.size()); end
    total++; if (period !== 32'd0) begin bad++; $display("FAIL timeout_period: got %0d want 0", period); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_busy: got %b want 1", busy); end
    timeout = 32'd0;
  endtask

  task automatic test_continuous();
    int ps_t[6];
    int h_t[6];
    int p_t[6];
    int n_t[6];
    logic [31:0] ep, eh;
    ps_t[0] = 0; h_t[0] = 40;  p_t[0] = 100;  n_t[0] = 4;
    ps_t[1] = 9; h_t[1] = 200; p_t[1] = 1000; n_t[1] = 2;
    for (int k = 2; k < 6; k++) begin
      ps_t[k] = $urandom_range(0, 7);
      h_t[k]  = $urandom_range(3, 60);
      p_t[k]  = h_t[k] + $urandom_range(3, 60);
      n_t[k]  = 3;
    end
    for (int k = 0; k < 6; k++) begin
      arm(ps_t[k], 2'b10);
      total++; if ({capture_int, busy} !== 2'b01) begin
        bad++; $display("FAIL cont_armed[%0d]: got int/busy=%b want 01", k, {capture_int, busy});
      end
      clear_q();
      run_pwm(h_t[k], p_t[k], n_t[k]);
      ep = 32'(p_t[k] / (ps_t[k] + 1));
      eh = 32'(h_t[k] / (ps_t[k] + 1));
      total++; if (vp.size() != n_t[k]) begin
        bad++; $display("FAIL cont_nvalid[%0d]: got %0d want %0d", k, vp.size(), n_t[k]);
      end
      for (int i = 0; i < vp.size() && i < n_t[k]; i++) begin
        total++; if (vp[i] !== ep) begin bad++; $display("FAIL cont_period[%0d.%0d]: got %0d want %0d", k, i, vp[i], ep); end
        total++; if (vh[i] !== eh) begin bad++; $display("FAIL cont_high[%0d.%0d]: got %0d want %0d", k, i, vh[i], eh); end
        if (i > 0) begin
          total++; if (vt[i] - vt[i-1] != p_t[k]) begin
            bad++; $display("FAIL cont_spacing[%0d.%0d]: got %0d want %0d", k, i, vt[i] - vt[i-1], p_t[k]);
          end
        end
      end
      total++; if ({capture_int, busy} !== 2'b11) begin
        bad++; $display("FAIL cont_after[%0d]: got int/busy=%b want 11", k, {capture_int, busy});
      end
    end
  endtask

  task automatic test_single();
    arm(0, 2'b01);
    clear_q();
    run_pwm(30, 100, 3);
    total++; if (vp.size() != 1) begin bad++; $display("FAIL single_nvalid: got %0d want 1", vp.size()); end
    if (vp.size() > 0) begin
      total++; if (vp[0] !== 32'd100) begin bad++; $display("FAIL single_period: got %0d want 100", vp[0]); end
      total++; if (vh[0] !== 32'd30) begin bad++; $display("FAIL single_high: got %0d want 30", vh[0]); end
    end
    total++; if ({capture_int, busy} !== 2'b10) begin
      bad++; $display("FAIL single_after: got int/busy=%b want 10", {capture_int, busy});
    end
  endtask

  task automatic test_reset_mid();
    int h, p;
    h = $urandom_range(20, 50);
    p = h + $urandom_range(10, 50);
    arm(0, 2'b10);
    run_pwm(h, p, 1);
    reset = 1'b0;
    tick_n(1);
    total++; if ({period, high_time} !== 64'd0) begin
      bad++; $display("FAIL midreset_values: got %0d/%0d want 0/0", period, high_time);
    end
    total++; if ({valid, capture_int, timeout_flag, busy} !== 4'b0000) begin
      bad++; $display("FAIL midreset_flags: got %b want 0000", {valid, capture_int, timeout_flag, busy});
    end
    reset  = 1'b1;
    pwm_in = 1'b0;
    clear_q();
    tick_n(10);
    total++; if (vp.size() != 0) begin bad++; $display("FAIL midreset_spurious: got %0d want 0", vp.size()); end
    run_pwm(h, p, 2);
    total++; if (vp.size() != 2) begin bad++; $display("FAIL midreset_nvalid: got %0d want 2", vp.size()); end
    for (int i = 0; i < vp.size() && i < 2; i++) begin
      total++; if (vp[i] !== 32'(p)) begin bad++; $display("FAIL midreset_period[%0d]: got %0d want %0d", i, vp[i], p); end
      total++; if (vh[i] !== 32'(h)) begin bad++; $display("FAIL midreset_high[%0d]: got %0d want %0d", i, vh[i], h); end
    end
  endtask

  task automatic test_mode_toggle();
    int ps, h, p;
    logic [31:0] ep, eh;
    ps = $urandom_range(0, 3);
    h  = $urandom_range(20, 60);
    p  = h + $urandom_range(10, 60);
    ep = 32'(p / (ps + 1));
    eh = 32'(h / (ps + 1));
    arm(ps, 2'b10);
    run_pwm(h, p, 2);
    clear_q();
    control = 2'b00;
    tick_n(1);
    total++; if ({capture_int, busy} !== 2'b00) begin
      bad++; $display("FAIL toggle_off: got int/busy=%b want 00", {capture_int, busy});
    end
    total++; if (period !== ep || high_time !== eh) begin
      bad++; $display("FAIL toggle_retain: got %0d/%0d want %0d/%0d", period, high_time, ep, eh);
    end
    control = 2'b10;
    tick_n(1);
    total++; if ({capture_int, busy} !== 2'b01) begin
      bad++; $display("FAIL toggle_on: got int/busy=%b want 01", {capture_int, busy});
    end
    tick_n(h - 10);
    pwm_in = 1'b0;
    tick_n(p - h);
    run_pwm(h, p, 1);
    total++; if (vp.size() != 1) begin bad++; $display("FAIL toggle_nvalid: got %0d want 1", vp.size()); end
    if (vp.size() > 0) begin
      total++; if (vp[0] !== ep || vh[0] !== eh) begin
        bad++; $display("FAIL toggle_next: got %0d/%0d want %0d/%0d", vp[0], vh[0], ep, eh);
      end
    end
    total++; if (capture_int !== 1'b1) begin bad++; $display("FAIL toggle_int: got %b want 1", capture_int); end
  endtask

  initial begin
    reset     = 1'b0;
    control   = 2'b00;
    prescalor = 32'd0;
    timeout   = 32'd0;
    pwm_in    = 1'b0;
    tick_n(2);
    test_reset();
    test_timeout();
    test_continuous();
    test_single();
    test_reset_mid();
    test_mode_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
